// File: rtl/row_col_cod_ramp_pkg.sv
// Shared helpers for the DCO capacitor-bank row/column ramp coder:
// target clamping, code -> (row, column) split, LFSR seed and a 16x16 output bundle type.
package dco_cod_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        int unsigned r;
        int unsigned c;
    } rc_t;

    typedef struct packed {
        logic [15:0] r_all;
        logic [15:0] row;
        logic [15:0] col;
    } cod16_t;

    function automatic int unsigned code_clamp(input int unsigned code, input int unsigned max_code);
        return (code > max_code) ? max_code : code;
    endfunction

    function automatic rc_t row_col_split(input int unsigned code, input int unsigned col_w);
        rc_t rc;
        rc.r = code / col_w;
        rc.c = code % col_w;
        return rc;
    endfunction

endpackage

// File: rtl/row_col_cod_ramp_dec.sv
// Combinational code -> bank decoder: rows below r fully on, row r one-hot,
// columns below c on within the active row.
module row_col_dec
    import dco_cod_pkg::*;
#(
    parameter int ROW_W  = 16,
    parameter int COL_W  = 16,
    parameter int WORD_W = $clog2(ROW_W*COL_W)
) (
    input  logic [WORD_W-1:0] i_code,
    output logic [ROW_W-1:0]  o_r_all,
    output logic [ROW_W-1:0]  o_row,
    output logic [COL_W-1:0]  o_col
);

    localparam logic [ROW_W-1:0] ONE_R = ROW_W'(1);
    localparam logic [COL_W-1:0] ONE_C = COL_W'(1);

    rc_t w_rc;

    assign w_rc = row_col_split(32'(i_code), COL_W);

    // A one-hot minus one is exactly the thermometer of everything below it.
    assign o_row   = ONE_R << w_rc.r;
    assign o_r_all = o_row - ONE_R;
    assign o_col   = (ONE_C << w_rc.c) - ONE_C;

endmodule

// File: rtl/row_col_cod_ramp.sv
// Slew-limited ramp from the current bank code to a clamped target, registered bank drive.
// Optional LFSR dither of the settled code when ROW_COL_COD_DITHER_EN is defined.
module row_col_cod_ramp
    import dco_cod_pkg::*;
#(
    parameter int ROW_W    = 16,
    parameter int COL_W    = 16,
    parameter int WORD_W   = $clog2(ROW_W*COL_W),
    parameter int STEP_MAX = 1,
    parameter int TICK_DIV = 1,
    parameter int RST_CODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef ROW_COL_COD_DITHER_EN
    input  logic              dith_en,
`endif
    input  logic [WORD_W-1:0] word,
    output logic [ROW_W-1:0]  r_all,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic [WORD_W-1:0] cur_code,
    output logic              busy,
    output logic              done
);

    localparam int                MAX_CODE = ROW_W*COL_W - 1;
    localparam int                STEP_EFF = (STEP_MAX > MAX_CODE) ? MAX_CODE : STEP_MAX;
    localparam logic [WORD_W-1:0] STEP     = WORD_W'(STEP_EFF);
    localparam logic [WORD_W-1:0] MAX_W    = WORD_W'(MAX_CODE);
    localparam logic [WORD_W-1:0] RST_W    = WORD_W'(RST_CODE);
    localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam rc_t              RST_RC   = row_col_split(RST_CODE, COL_W);
    localparam logic [ROW_W-1:0] ONE_R    = ROW_W'(1);
    localparam logic [COL_W-1:0] ONE_C    = COL_W'(1);
    localparam logic [ROW_W-1:0] RST_ROW  = ONE_R << RST_RC.r;
    localparam logic [ROW_W-1:0] RST_RALL = RST_ROW - ONE_R;
    localparam logic [COL_W-1:0] RST_COL  = (ONE_C << RST_RC.c) - ONE_C;

    logic [WORD_W-1:0] r_tgt, r_cur;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy, r_done;
    logic [ROW_W-1:0]  r_thermo, r_row;
    logic [COL_W-1:0]  r_col;

    logic [WORD_W-1:0] w_tgt_nxt, w_cur_nxt, w_diff, w_app;
    logic              w_tick, w_busy_nxt, w_dbit;
    logic [ROW_W-1:0]  w_thermo, w_row;
    logic [COL_W-1:0]  w_col;

    assign w_tgt_nxt = WORD_W'(code_clamp(32'(word), MAX_CODE));
    assign w_tick    = (r_cnt == CNT_LAST);

    // Step toward the previously registered target; the min() keeps us from overshooting.
    always_comb begin
        w_cur_nxt = r_cur;
        w_diff    = '0;
        if (w_tick) begin
            if (r_cur < r_tgt) begin
                w_diff    = r_tgt - r_cur;
                w_cur_nxt = r_cur + ((w_diff > STEP) ? STEP : w_diff);
            end else if (r_cur > r_tgt) begin
                w_diff    = r_cur - r_tgt;
                w_cur_nxt = r_cur - ((w_diff > STEP) ? STEP : w_diff);
            end
        end
    end

    assign w_busy_nxt = (w_cur_nxt != w_tgt_nxt);

`ifdef ROW_COL_COD_DITHER_EN
    logic [15:0] r_lfsr, w_lfsr_nxt;

    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // Dither only a settled code, and never past the top of the bank.
    assign w_dbit = dith_en & ~w_busy_nxt & w_lfsr_nxt[0] & (w_cur_nxt != MAX_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    r_lfsr <= LFSR_SEED;
        else if (en) r_lfsr <= w_lfsr_nxt;
    end
`else
    assign w_dbit = 1'b0;
`endif

    assign w_app = w_cur_nxt + WORD_W'(w_dbit);

    row_col_dec #(
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .WORD_W (WORD_W)
    ) u_dec (
        .i_code  (w_app),
        .o_r_all (w_thermo),
        .o_row   (w_row),
        .o_col   (w_col)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tgt    <= RST_W;
            r_cur    <= RST_W;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_thermo <= RST_RALL;
            r_row    <= RST_ROW;
            r_col    <= RST_COL;
        end else begin
            r_done <= 1'b0;
            if (en) begin
                r_tgt    <= w_tgt_nxt;
                r_cur    <= w_cur_nxt;
                r_cnt    <= w_tick ? '0 : r_cnt + CNT_W'(1);
                r_busy   <= w_busy_nxt;
                r_done   <= w_tick & r_busy & ~w_busy_nxt;
                r_thermo <= w_thermo;
                r_row    <= w_row;
                r_col    <= w_col;
            end
        end
    end

    assign r_all    = r_thermo;
    assign row      = r_row;
    assign col      = r_col;
    assign cur_code = r_cur;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
